xspi_nor_cmd_seq: RTL and testbench

- Command sequencer for the quad-SPI slave PHY. It sits between the PHY's transaction interface and a synchronous memory/register port.
- It decodes a NOR-flash style command stream (opcode, address, dummy, data) one PHY transaction at a time.
- For each phase it programs the PHY's bit count, direction and transmit word.
- It converts address/data phases into word-wide memory reads (with prefetch) and writes.

---
 rtl/xspi_nor_cmd_seq_if.sv | 23 ++
 rtl/xspi_nor_cmd_seq.sv | 217 +++++++++++++++++++++
 tb/tb_xspi_nor_cmd_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xspi_nor_cmd_seq_if.sv
// Word-wide synchronous memory port between the NOR command sequencer (master)
// and the backing memory or register file (slave).
interface xspi_nor_cmd_seq_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 24
);
  logic                 req;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rvalid;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/xspi_nor_cmd_seq.sv
// Quad-SPI NOR command sequencer: decodes opcode/address/dummy/data phases one
// PHY transaction at a time and maps them onto word-wide memory reads and writes.
//   state  | meaning
//   CMD    | receiving the 8-bit opcode
//   ADDR   | receiving the address
//   DUMMY  | turnaround before read data
//   RDATA  | driving read words (memory or ID) to the host
//   WDATA  | receiving words to write
//   SINK   | unknown opcode, discard everything
module xspi_nor_cmd_seq #(
  parameter int          WORD_SIZE        = 32,
  parameter int          CYCLE_COUNT_BITS = 6,
  parameter int          ADDR_BITS        = 24,
  parameter int          DUMMY_BITS       = 8,
  parameter logic [31:0] ID_VALUE         = 32'h00C2_2018
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  output logic [CYCLE_COUNT_BITS-1:0] txnbc_o,
  output logic                        txndir_o,
  output logic [WORD_SIZE-1:0]        txndata_o,
  input  logic [WORD_SIZE-1:0]        txndata_i,
  input  logic                        txndone_i,
  xspi_nor_cmd_seq_if.master          mem,
  output logic [7:0]                  opcode_o,
  output logic                        underrun_o
);

  localparam logic [7:0] OP_READ    = 8'hEB;
  localparam logic [7:0] OP_WRITE   = 8'h32;
  localparam logic [7:0] OP_READ_ID = 8'h9F;

  localparam logic [CYCLE_COUNT_BITS-1:0] BC_CMD   = CYCLE_COUNT_BITS'(8);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR  = CYCLE_COUNT_BITS'(ADDR_BITS);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_DUMMY = CYCLE_COUNT_BITS'(DUMMY_BITS);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_WORD  = CYCLE_COUNT_BITS'(WORD_SIZE);
  localparam logic [ADDR_BITS-1:0]        ADDR_STEP = ADDR_BITS'(WORD_SIZE / 8);
  localparam logic [WORD_SIZE-1:0]        ID_WORD   = WORD_SIZE'(ID_VALUE);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_SINK
  } state_t;

  state_t                      state_q,     state_d;
  logic [CYCLE_COUNT_BITS-1:0] txnbc_q,     txnbc_d;
  logic                        txndir_q,    txndir_d;
  logic [WORD_SIZE-1:0]        txndata_q,   txndata_d;
  logic                        mem_req_q,   mem_req_d;
  logic                        mem_we_q,    mem_we_d;
  logic [ADDR_BITS-1:0]        mem_addr_q,  mem_addr_d;
  logic [WORD_SIZE-1:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]                  opcode_q,    opcode_d;
  logic                        underrun_q,  underrun_d;
  logic [ADDR_BITS-1:0]        addr_q,      addr_d;
  logic [WORD_SIZE-1:0]        buf_q,       buf_d;
  logic                        buf_vld_q,   buf_vld_d;
  logic                        rd_out_q,    rd_out_d;
  logic                        rvalid_ok;

  // Returns with no read outstanding (e.g. a read issued before reset) are dropped.
  assign rvalid_ok = mem.rvalid && rd_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_CMD;
      txnbc_q     <= BC_CMD;
      txndir_q    <= 1'b0;
      txndata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      opcode_q    <= '0;
      underrun_q  <= 1'b0;
      addr_q      <= '0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      rd_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      txnbc_q     <= txnbc_d;
      txndir_q    <= txndir_d;
      txndata_q   <= txndata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      opcode_q    <= opcode_d;
      underrun_q  <= underrun_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      rd_out_q    <= rd_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    txnbc_d     = txnbc_q;
    txndir_d    = txndir_q;
    txndata_d   = txndata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    opcode_d    = opcode_q;
    underrun_d  = underrun_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    rd_out_d    = rd_out_q;

    if (rvalid_ok) begin
      buf_d     = mem.rdata;
      buf_vld_d = 1'b1;
      rd_out_d  = 1'b0;
    end

    if (txndone_i) begin
      unique case (state_q)
        S_CMD: begin
          opcode_d = txndata_i[7:0];
          if (txndata_i[7:0] == OP_READ || txndata_i[7:0] == OP_WRITE) begin
            state_d  = S_ADDR;
            txnbc_d  = BC_ADDR;
            txndir_d = 1'b0;
          end else if (txndata_i[7:0] == OP_READ_ID) begin
            state_d   = S_RDATA;
            txnbc_d   = BC_WORD;
            txndir_d  = 1'b1;
            txndata_d = ID_WORD;
          end else begin
            state_d  = S_SINK;
            txnbc_d  = BC_WORD;
            txndir_d = 1'b0;
          end
        end

        S_ADDR: begin
          addr_d = txndata_i[ADDR_BITS-1:0];
          if (opcode_q == OP_WRITE) begin
            state_d  = S_WDATA;
            txnbc_d  = BC_WORD;
            txndir_d = 1'b0;
          end else begin
            state_d    = S_DUMMY;
            txnbc_d    = BC_DUMMY;
            txndir_d   = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = txndata_i[ADDR_BITS-1:0];
            rd_out_d   = 1'b1;
          end
        end

        S_DUMMY, S_RDATA: begin
          if (state_q == S_RDATA && opcode_q == OP_READ_ID) begin
            txndata_d = ID_WORD;
          end else begin
            state_d  = S_RDATA;
            txnbc_d  = BC_WORD;
            txndir_d = 1'b1;
            if (buf_vld_q) begin
              txndata_d = buf_q;
              buf_vld_d = rvalid_ok;
            end else if (rvalid_ok) begin
              txndata_d = mem.rdata;
              buf_vld_d = 1'b0;
            end else begin
              txndata_d  = '1;
              underrun_d = 1'b1;
            end
            addr_d = addr_q + ADDR_STEP;
            // Prefetch only when the single read slot and the buffer are both free.
            if (!rd_out_d && !buf_vld_d) begin
              mem_req_d  = 1'b1;
              mem_addr_d = addr_q + ADDR_STEP;
              rd_out_d   = 1'b1;
            end
          end
        end

        S_WDATA: begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = txndata_i;
          addr_d      = addr_q + ADDR_STEP;
        end

        S_SINK: begin
          txnbc_d  = BC_WORD;
          txndir_d = 1'b0;
        end

        default: begin
          state_d = S_CMD;
        end
      endcase
    end
  end

  assign txnbc_o    = txnbc_q;
  assign txndir_o   = txndir_q;
  assign txndata_o  = txndata_q;
  assign mem.req    = mem_req_q;
  assign mem.we     = mem_we_q;
  assign mem.addr   = mem_addr_q;
  assign mem.wdata  = mem_wdata_q;
  assign opcode_o   = opcode_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_xspi_nor_cmd_seq.sv
// Scoreboard bench for xspi_nor_cmd_seq: stimulus queues expected phase setups and
// memory requests; a monitor pops and compares them as the DUT produces them.
module tb_xspi_nor_cmd_seq;

  typedef struct packed {
    logic [5:0]  bc;
    logic        dir;
    logic [31:0] data;
    logic        chk_data;
  } ph_t;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
  } mr_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  txnbc;
  logic        txndir;
  logic [31:0] txndata_o;
  logic [31:0] txndata_i;
  logic        txndone;
  logic [7:0]  opcode;
  logic        underrun;

  xspi_nor_cmd_seq_if #(.WORD_SIZE(32), .ADDR_BITS(24)) mem_if ();

  xspi_nor_cmd_seq dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .txnbc_o    (txnbc),
    .txndir_o   (txndir),
    .txndata_o  (txndata_o),
    .txndata_i  (txndata_i),
    .txndone_i  (txndone),
    .mem        (mem_if.master),
    .opcode_o   (opcode),
    .underrun_o (underrun)
  );

  int checks   = 0;
  int failures = 0;

  ph_t         ph_q[$];
  mr_t         mr_q[$];
  logic [31:0] rd_q[$];
  logic        mem_hold  = 1'b0;
  logic        mem_flush = 1'b0;
  logic        mem_pend  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers each read one cycle later unless held back.
  initial begin
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;
    forever begin
      @(negedge clk);
      mem_if.rvalid = 1'b0;
      if (mem_flush) begin
        mem_pend = 1'b0;
      end else if (mem_pend && !mem_hold) begin
        mem_pend      = 1'b0;
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
      end else if (mem_if.req && !mem_if.we) begin
        if (mem_hold) begin
          mem_pend = 1'b1;
        end else begin
          mem_if.rvalid = 1'b1;
          mem_if.rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end
      end
    end
  end

  // Monitor: phase setup after each done edge, and every memory request.
  initial begin
    logic done_at_edge;
    ph_t  ep;
    mr_t  em;
    forever begin
      @(posedge clk);
      done_at_edge = txndone && rst_n;
      #1;
      if (done_at_edge) begin
        if (ph_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL phase_unexpected: bc=%0d dir=%0d with no expectation", txnbc, txndir);
        end else begin
          ep = ph_q.pop_front();
          check("phase_bc", 32'(txnbc), 32'(ep.bc));
          check("phase_dir", 32'(txndir), 32'(ep.dir));
          if (ep.chk_data) check("phase_txdata", txndata_o, ep.data);
        end
      end
      if (mem_if.req) begin
        if (mr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_req_unexpected: we=%0d addr=%h", mem_if.we, mem_if.addr);
        end else begin
          em = mr_q.pop_front();
          check("mem_we", 32'(mem_if.we), 32'(em.we));
          check("mem_addr", 32'(mem_if.addr), 32'(em.addr));
          if (em.we) check("mem_wdata", mem_if.wdata, em.wdata);
        end
      end
    end
  end

  task automatic exp_ph(input int bc, input logic dir, input logic [31:0] d, input logic chk);
    ph_t p;
    p.bc = 6'(bc); p.dir = dir; p.data = d; p.chk_data = chk;
    ph_q.push_back(p);
  endtask

  task automatic exp_mr(input logic we, input logic [23:0] a, input logic [31:0] d);
    mr_t m;
    m.we = we; m.addr = a; m.wdata = d;
    mr_q.push_back(m);
  endtask

  task automatic phase(input logic [31:0] d);
    @(negedge clk);
    txndata_i = d;
    txndone   = 1'b1;
    @(negedge clk);
    txndone   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_flush = 1'b1;
    repeat (2) @(negedge clk);
    mem_flush = 1'b0;
    mem_hold  = 1'b0;
    rd_q.delete();
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    txndata_i = '0;
    txndone   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_txnbc", 32'(txnbc), 32'd8);
    check("rst_txndir", 32'(txndir), 32'd0);
    check("rst_txndata", txndata_o, 32'h0);
    check("rst_mem_req", 32'(mem_if.req), 32'd0);
    check("rst_mem_we", 32'(mem_if.we), 32'd0);
    check("rst_mem_addr", 32'(mem_if.addr), 32'd0);
    check("rst_mem_wdata", mem_if.wdata, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // READ_ID: ID word on every data phase, no memory traffic
    exp_ph(32, 1'b1, 32'h00C2_2018, 1'b1);
    phase(32'h0000_009F);
    check("id_opcode", 32'(opcode), 32'h9F);
    exp_ph(32, 1'b1, 32'h00C2_2018, 1'b1);
    phase(32'h0);
    exp_ph(32, 1'b1, 32'h00C2_2018, 1'b1);
    phase(32'h0);

    // READ from 0x100 with prefetch
    do_reset();
    rd_q.push_back(32'hDEAD_BEEF);
    rd_q.push_back(32'h0123_4567);
    rd_q.push_back(32'h89AB_CDEF);
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_00EB);
    check("rd_opcode", 32'(opcode), 32'hEB);
    exp_mr(1'b0, 24'h000100, 32'h0);
    exp_ph(8, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0100);
    exp_mr(1'b0, 24'h000104, 32'h0);
    exp_ph(32, 1'b1, 32'hDEAD_BEEF, 1'b1);
    phase(32'h0);
    exp_mr(1'b0, 24'h000108, 32'h0);
    exp_ph(32, 1'b1, 32'h0123_4567, 1'b1);
    phase(32'h0);
    check("rd_underrun", 32'(underrun), 32'd0);

    // READ with data late: underrun, sticky
    do_reset();
    rd_q.push_back(32'hCAFE_F00D);
    mem_hold = 1'b1;
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_00EB);
    exp_mr(1'b0, 24'h000200, 32'h0);
    exp_ph(8, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0200);
    exp_ph(32, 1'b1, 32'hFFFF_FFFF, 1'b1);
    phase(32'h0);
    check("ur_underrun_set", 32'(underrun), 32'd1);
    mem_hold = 1'b0;
    repeat (3) @(negedge clk);
    exp_mr(1'b0, 24'h000208, 32'h0);
    exp_ph(32, 1'b1, 32'hCAFE_F00D, 1'b1);
    phase(32'h0);
    check("ur_underrun_sticky", 32'(underrun), 32'd1);

    // WRITE across the address wrap
    do_reset();
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0032);
    check("wr_opcode", 32'(opcode), 32'h32);
    exp_ph(32, 1'b0, 32'h0, 1'b0);
    phase(32'h00FF_FFFC);
    exp_mr(1'b1, 24'hFFFFFC, 32'hAABB_CCDD);
    exp_ph(32, 1'b0, 32'h0, 1'b0);
    phase(32'hAABB_CCDD);
    exp_mr(1'b1, 24'h000000, 32'h1122_3344);
    exp_ph(32, 1'b0, 32'h0, 1'b0);
    phase(32'h1122_3344);

    // Unknown opcode sinks data, then a fresh READ decodes normally
    do_reset();
    exp_ph(32, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0055);
    check("sink_opcode", 32'(opcode), 32'h55);
    for (int i = 0; i < 3; i++) begin
      exp_ph(32, 1'b0, 32'h0, 1'b0);
      phase(32'h1234_0000 + 32'(i));
    end
    do_reset();
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_00EB);
    check("sink_then_read_opcode", 32'(opcode), 32'hEB);

    // Reset mid-RDATA with a prefetch in flight; its late return must be ignored
    do_reset();
    rd_q.push_back(32'h55AA_55AA);
    rd_q.push_back(32'h7777_7777);
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_00EB);
    exp_mr(1'b0, 24'h000300, 32'h0);
    exp_ph(8, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0300);
    mem_hold = 1'b1;
    exp_mr(1'b0, 24'h000304, 32'h0);
    exp_ph(32, 1'b1, 32'h55AA_55AA, 1'b1);
    phase(32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_txnbc", 32'(txnbc), 32'd8);
    check("mid_rst_txndir", 32'(txndir), 32'd0);
    check("mid_rst_mem_req", 32'(mem_if.req), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    repeat (4) @(negedge clk);
    mem_hold = 1'b1;
    exp_ph(24, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_00EB);
    exp_mr(1'b0, 24'h000400, 32'h0);
    exp_ph(8, 1'b0, 32'h0, 1'b0);
    phase(32'h0000_0400);
    exp_ph(32, 1'b1, 32'hFFFF_FFFF, 1'b1);
    phase(32'h0);
    check("late_rvalid_underrun", 32'(underrun), 32'd1);
    do_reset();

    repeat (4) @(negedge clk);
    check("phase_queue_drained", 32'(ph_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
